// File: rtl/line_writeback_drain_pkg.sv
// Shared definitions for the write-back FIFO entry layout and the drain FSM.
// The cache-side writer packs entries with the same field helpers used here.
package line_writeback_drain_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_WORDS         = 4;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic int entry_width(input int address_width, input int words, input int data_width);
    return address_width + words * data_width;
  endfunction

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int line_offset_bits(input int words, input int data_width);
    return log2_ceil(words * data_width / 8);
  endfunction

  // Entry layout: {line_address, word[WORDS-1], ..., word[0]}
  function automatic int entry_address_lsb(input int words, input int data_width);
    return words * data_width;
  endfunction

  function automatic int entry_word_lsb(input int index, input int data_width);
    return index * data_width;
  endfunction

  localparam int ENTRY_WIDTH      = entry_width(DEFAULT_ADDRESS_WIDTH, DEFAULT_WORDS, DEFAULT_DATA_WIDTH);
  localparam int BYTES_PER_WORD   = bytes_per_word(DEFAULT_DATA_WIDTH);
  localparam int LINE_OFFSET_BITS = line_offset_bits(DEFAULT_WORDS, DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/line_writeback_drain.sv
// Drains cache lines from the write-back FIFO head and serialises each one
// into WORDS single-word memory write beats over a valid/ready handshake.
module line_writeback_drain
  import line_writeback_drain_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int WORDS         = 4,
  localparam int ENTRY_WIDTH  = entry_width(ADDRESS_WIDTH, WORDS, DATA_WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     drain_enable,
  input  logic                     fifo_empty,
  input  logic [ENTRY_WIDTH-1:0]   fifo_data,
  output logic                     fifo_read,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic [15:0]              lines_drained
);

  localparam int BEAT_BITS   = log2_ceil(WORDS);
  localparam int LINE_BITS   = WORDS * DATA_WIDTH;
  localparam int BYTES       = bytes_per_word(DATA_WIDTH);
  localparam int OFFSET_BITS = line_offset_bits(WORDS, DATA_WIDTH);
  localparam int ADDR_LSB    = entry_address_lsb(WORDS, DATA_WIDTH);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS - 1);

  state_t                   state_r;
  state_t                   next_state_s;
  logic [BEAT_BITS-1:0]     beat_r;
  logic [ADDRESS_WIDTH-1:0] line_base_r;
  logic [LINE_BITS-1:0]     line_words_r;
  logic [15:0]              lines_drained_r;

  logic                     pop_s;
  logic                     sending_s;
  logic                     accept_s;
  logic                     last_beat_s;
  logic [ADDRESS_WIDTH-1:0] fifo_base_s;
  logic [ADDRESS_WIDTH-1:0] beat_address_s;
  logic [DATA_WIDTH-1:0]    beat_data_s;
  logic                     unused_offset_s;

  // Line offset bits of the captured address are dropped: the base is line-aligned by construction.
  assign fifo_base_s     = {fifo_data[ADDR_LSB + OFFSET_BITS +: (ADDRESS_WIDTH - OFFSET_BITS)],
                            {OFFSET_BITS{1'b0}}};
  assign unused_offset_s = ^fifo_data[ADDR_LSB +: OFFSET_BITS];
  assign beat_address_s  = line_base_r + (ADDRESS_WIDTH'(beat_r) * ADDRESS_WIDTH'(BYTES));
  assign beat_data_s     = line_words_r[entry_word_lsb(int'(beat_r), DATA_WIDTH) +: DATA_WIDTH];

  // Next-state and handshake decode.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    sending_s    = 1'b0;
    accept_s     = 1'b0;
    last_beat_s  = (beat_r == LAST_BEAT);
    case (state_r)
      IDLE: begin
        if (!fifo_empty && drain_enable) begin
          pop_s        = 1'b1;
          next_state_s = SEND;
        end else begin
          next_state_s = IDLE;
        end
      end
      SEND: begin
        sending_s = 1'b1;
        accept_s  = mem_ready;
        if (mem_ready && last_beat_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SEND;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Line capture and beat sequencing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_r       <= '0;
      line_base_r  <= '0;
      line_words_r <= '0;
    end else if (pop_s) begin
      beat_r       <= '0;
      line_base_r  <= fifo_base_s;
      line_words_r <= fifo_data[LINE_BITS-1:0];
    end else if (accept_s && !last_beat_s) begin
      beat_r       <= beat_r + BEAT_BITS'(1);
    end else begin
      beat_r       <= beat_r;
    end
  end

  // Completed-line counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lines_drained_r <= 16'd0;
    end else if (accept_s && last_beat_s) begin
      lines_drained_r <= lines_drained_r + 16'd1;
    end else begin
      lines_drained_r <= lines_drained_r;
    end
  end

  // The pop strobe is combinational in IDLE, so it is masked while reset is high.
  assign fifo_read     = pop_s & ~reset;
  assign mem_write     = sending_s;
  assign busy          = sending_s;
  assign mem_address   = sending_s ? beat_address_s : {ADDRESS_WIDTH{1'b0}};
  assign mem_data      = sending_s ? beat_data_s : {DATA_WIDTH{1'b0}};
  assign lines_drained = lines_drained_r;

endmodule

// File: doc/line_writeback_drain.md
Name: line_writeback_drain

Overview:
- Consumer at the read end of the write-back FIFO that sits between the cache and main memory.
- Pops one cache-line entry from the FIFO and serialises it into WORDS single-word memory write beats, using a valid/ready handshake.
- Gives the FIFO's write-side producer (the cache) a matching drain engine, so buffered dirty lines reach main memory with no cache involvement.

Parameters:
- DATA_WIDTH, 32, width of one memory word in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 32, byte-address width.
- WORDS, 4, words per cache line; must be a power of 2 and at least 2.
- ENTRY_WIDTH (localparam), ADDRESS_WIDTH + WORDS*DATA_WIDTH, width of one FIFO entry.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- drain_enable  in  1  permits starting a new line; sampled only in IDLE.
- fifo_empty  in  1  empty flag from the FIFO.
- fifo_data  in  ENTRY_WIDTH  head entry from the FIFO, packed as {line_address, word[WORDS-1], ..., word[0]}.
- fifo_read  out  1  pop strobe to the FIFO.
- mem_write  out  1  memory write-beat valid.
- mem_address  out  ADDRESS_WIDTH  byte address of the current beat.
- mem_data  out  DATA_WIDTH  data of the current beat.
- mem_ready  in  1  memory accepts the beat on the rising edge where mem_write && mem_ready.
- busy  out  1  high while a line is in flight.
- lines_drained  out  16  count of completed lines; wraps from 0xFFFF to 0.

Behaviour:
- Reset: asynchronous, active-high. Forces state to IDLE and beat counter, line register, and lines_drained to 0. All outputs read 0 while reset is high.
- Reset mid-burst: aborts the burst immediately. The line already popped is lost; this is accepted behaviour, and the system resets cache and memory together.
- State IDLE:
  - fifo_read = !fifo_empty && drain_enable, decoded combinationally from registered state and inputs.
  - The FIFO head is valid combinationally, so on the edge where fifo_read=1 the block captures fifo_data into the line register, clears the beat counter, and moves to SEND.
  - mem_write=0, busy=0.
- State SEND:
  - mem_write=1, busy=1, fifo_read=0.
  - mem_data = word[beat].
  - mem_address = {line_address[ADDRESS_WIDTH-1 : log2(WORDS*DATA_WIDTH/8)], zeros} + beat*(DATA_WIDTH/8). Low line-offset bits of the captured address are ignored; the address is line-aligned by construction.
  - mem_write, mem_address and mem_data are stable while mem_ready=0; no beat is dropped or repeated.
  - On mem_write && mem_ready with beat < WORDS-1: beat increments.
  - On mem_write && mem_ready with beat == WORDS-1: lines_drained increments and state returns to IDLE.
- Latency and throughput:
  - One IDLE cycle (the pop cycle) precedes every line.
  - With mem_ready held high, a line takes WORDS+1 cycles: 1 pop + WORDS beats.
  - Back-to-back lines are separated by exactly that one pop cycle.
- drain_enable only gates the start of a line. Deasserting it mid-burst does not stall or abort the burst.
- fifo_empty rising during SEND has no effect; the line is already captured.
- At most one pop per line. fifo_read is never asserted when fifo_empty=1.

Decomposition:
- Shared package holds: state encoding (IDLE=1'b0, SEND=1'b1), the log2 function, ENTRY_WIDTH, BYTES_PER_WORD, LINE_OFFSET_BITS.
- Entry pack/unpack field positions also go in the package, so the cache-side writer and this drain use identical layouts.
- No sub-module: a single FSM plus datapath.
- The bench instantiates this block with the existing fifo (DATA_WIDTH=ENTRY_WIDTH, DEPTH=8) and a memory model.

Test Plan:
- Reset values: assert reset asynchronously between clock edges -> all outputs 0 immediately, lines_drained=0, state IDLE; no fifo_read while fifo_empty=1.
- Single line, no backpressure: push {0x0000_0104, 0xD,0xC,0xB,0xA}, drain_enable=1, mem_ready=1 -> fifo_read high 1 cycle; beats (0x100,0xA), (0x104,0xB), (0x108,0xC), (0x10C,0xD) on 4 consecutive cycles; busy high 4 cycles; lines_drained=1.
- Backpressure: hold mem_ready=0 for 3 cycles on beat 1 -> mem_address=0x104 and mem_data=0xB held stable; 4 beats total, no duplicates; line takes 8 cycles.
- Back-to-back lines: push 3 lines -> exactly one idle pop cycle between bursts; 15 cycles total; lines_drained=3; FIFO ends empty.
- Enable gating: drain_enable=0 with FIFO non-empty -> no pop for 10 cycles. Drop drain_enable after beat 0 -> burst still completes all 4 beats, then no further pop.
- Reset mid-burst: assert reset during beat 2 -> mem_write drops asynchronously. After release, the next FIFO entry drains normally starting at beat 0; lines_drained restarts from 0.
